// File: rtl/keypad_scan_if.sv
// Keypad scanner signal bundle: matrix row/column lines plus the key event outputs.
//   IN_row          row sense lines into the scanner (active-high)
//   OUT_col         one-hot column drive from the scanner
//   OUT_key_code    linear code row*COLS+col of the accepted key
//   OUT_key_valid   one-cycle press (and repeat) event
//   OUT_key_held    high while a key is accepted and not yet released
//   OUT_key_release one-cycle release event
// master: the scanner; slave: the board/consumer side.
interface keypad_scan_if #(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4
);
    localparam int unsigned CODE_W = $clog2(ROWS * COLS);

    logic [ROWS-1:0]   IN_row;
    logic [COLS-1:0]   OUT_col;
    logic [CODE_W-1:0] OUT_key_code;
    logic              OUT_key_valid;
    logic              OUT_key_held;
    logic              OUT_key_release;

    modport master (
        input  IN_row,
        output OUT_col,
        output OUT_key_code,
        output OUT_key_valid,
        output OUT_key_held,
        output OUT_key_release
    );

    modport slave (
        output IN_row,
        input  OUT_col,
        input  OUT_key_code,
        input  OUT_key_valid,
        input  OUT_key_held,
        input  OUT_key_release
    );
endinterface

// File: rtl/keypad_scan.sv
// Matrix keypad scanner: drives one column at a time, debounces a single
// pressed key, rejects ghost/multi-key samples and reports press/release events.
// Ports:
//   IN_clk      rising-edge clock
//   IN_reset_n  asynchronous active-low reset
//   kp          keypad_scan_if.master (row sense in, column drive and key events out)
// Parameters: ROWS 2..8, COLS 2..8, SCAN_DIV >= 3, DEBOUNCE_CYCLES >= 1,
//   REPEAT_DELAY / REPEAT_RATE (auto-repeat timing).
// Build option: define KEYPAD_AUTOREPEAT_EN to add auto-repeat of OUT_key_valid
//   while a key is held; without it exactly one valid pulse is issued per press.
module keypad_scan #(
    parameter int unsigned ROWS            = 4,
    parameter int unsigned COLS            = 4,
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000
) (
    input  logic          IN_clk,
    input  logic          IN_reset_n,
    keypad_scan_if.master kp
);
    localparam int unsigned ROW_W   = $clog2(ROWS);
    localparam int unsigned COL_W   = $clog2(COLS);
    localparam int unsigned CODE_W  = $clog2(ROWS * COLS);
    localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t             state;
    logic [ROWS-1:0]    row_meta;
    logic [ROWS-1:0]    row_s;
    logic [COL_W-1:0]   col_idx;
    logic [ROW_W-1:0]   row_idx;
    logic [DWELL_W-1:0] dwell;
    logic [DEB_W-1:0]   deb_cnt;

    logic [COL_W-1:0]   col_nxt;
    logic [ROW_W-1:0]   row_hit;
    logic               row_single;
    logic               row_match;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_armed;     // first repeat already issued; later ones use REPEAT_RATE
`else
    // Repeat timing has no effect in this build; kept so instantiations are build-independent.
    if (REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_repeat_unused
    end
`endif

    function automatic logic [COLS-1:0] col_onehot(input logic [COL_W-1:0] idx);
        return COLS'(1) << idx;
    endfunction

    // Next column, wrapping at COLS (which need not be a power of two).
    assign col_nxt    = (col_idx == COL_LAST) ? '0 : col_idx + COL_W'(1);
    assign row_single = $onehot(row_s);
    assign row_match  = (row_s == (ROWS'(1) << row_idx));

    // Index of the asserted row; only meaningful when row_single is set.
    always_comb begin
        row_hit = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (row_s[i]) row_hit = ROW_W'(i);
        end
    end

    // Synchroniser, scan/debounce state machine and registered outputs.
    always_ff @(posedge IN_clk or negedge IN_reset_n) begin
        if (!IN_reset_n) begin
            state              <= SCAN;
            row_meta           <= '0;
            row_s              <= '0;
            col_idx            <= '0;
            row_idx            <= '0;
            dwell              <= '0;
            deb_cnt            <= '0;
            kp.OUT_col         <= '0;
            kp.OUT_key_code    <= '0;
            kp.OUT_key_valid   <= 1'b0;
            kp.OUT_key_held    <= 1'b0;
            kp.OUT_key_release <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt            <= '0;
            rep_armed          <= 1'b0;
`endif
        end else begin
            row_meta           <= kp.IN_row;
            row_s              <= row_meta;
            kp.OUT_key_valid   <= 1'b0;
            kp.OUT_key_release <= 1'b0;

            case (state)
                SCAN: begin
                    // Column output is zero only straight after reset: start the
                    // first dwell on the edge that first drives the column.
                    if (kp.OUT_col == '0) begin
                        kp.OUT_col <= col_onehot(col_idx);
                        dwell      <= '0;
                    end else if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (row_single) begin
                            row_idx <= row_hit;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx    <= col_nxt;
                            kp.OUT_col <= col_onehot(col_nxt);
                        end
                    end else begin
                        dwell <= dwell + DWELL_W'(1);
                    end
                end

                DEBOUNCE: begin
                    if (!row_match) begin
                        col_idx    <= col_nxt;
                        kp.OUT_col <= col_onehot(col_nxt);
                        dwell      <= '0;
                        state      <= SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        kp.OUT_key_code  <= CODE_W'(32'(row_idx) * COLS + 32'(col_idx));
                        kp.OUT_key_valid <= 1'b1;
                        kp.OUT_key_held  <= 1'b1;
                        state            <= PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt          <= '0;
                        rep_armed        <= 1'b0;
`endif
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end

                PRESSED: begin
                    // Only the accepted row matters here; other rows are ignored.
                    if (!row_s[row_idx]) begin
                        deb_cnt <= '0;
                        state   <= RELEASE;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (rep_cnt == (rep_armed ? REP_RATE_LAST : REP_DELAY_LAST)) begin
                        kp.OUT_key_valid <= 1'b1;
                        rep_cnt          <= '0;
                        rep_armed        <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
`endif
                end

                RELEASE: begin
                    // A returning row bit is bounce: resume PRESSED silently.
                    if (row_s[row_idx]) begin
                        state <= PRESSED;
                    end else if (deb_cnt == DEB_LAST) begin
                        kp.OUT_key_release <= 1'b1;
                        kp.OUT_key_held    <= 1'b0;
                        col_idx            <= '0;
                        kp.OUT_col         <= col_onehot('0);
                        dwell              <= '0;
                        state              <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end

                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// Testbench for keypad_scan: a 4x4 instance and a 3x5 instance (auto-repeat
// timing 20/10), both with SCAN_DIV=4 and DEBOUNCE_CYCLES=4, driven by a
// key-matrix model that closes row lines from the pressed-key set and the
// driven column.
module tb_keypad_scan;
    localparam int unsigned SD        = 4;
    localparam int unsigned DEB       = 4;
    localparam int unsigned R35_DELAY = 20;
    localparam int unsigned R35_RATE  = 10;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [15:0] keys4;
    logic [14:0] keys35;
    logic [3:0]  force4;
    logic [3:0]  row4;
    logic [2:0]  row35;

    int          v4[$];
    int          r4[$];
    int          v35[$];
    int          r35[$];
    logic [3:0]  c4[$];
    logic [3:0]  c35[$];
    int          vh_bad   = 0;
    int          rh_bad   = 0;
    int          both_bad = 0;
    logic        held4_prev  = 1'b0;
    logic        held35_prev = 1'b0;

    keypad_scan_if #(.ROWS(4), .COLS(4)) k4 ();
    keypad_scan_if #(.ROWS(3), .COLS(5)) k35 ();

    keypad_scan #(
        .ROWS(4), .COLS(4), .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DEB)
    ) u_dut4 (
        .IN_clk(clk), .IN_reset_n(rst_n), .kp(k4)
    );

    keypad_scan #(
        .ROWS(3), .COLS(5), .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(R35_DELAY), .REPEAT_RATE(R35_RATE)
    ) u_dut35 (
        .IN_clk(clk), .IN_reset_n(rst_n), .kp(k35)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Key matrix: a pressed key connects its row to its column.
    always_comb begin
        row4 = force4;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys4[r*4+c] && k4.OUT_col[c]) row4[r] = 1'b1;
    end
    always_comb begin
        row35 = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++)
                if (keys35[r*5+c] && k35.OUT_col[c]) row35[r] = 1'b1;
    end
    assign k4.IN_row  = row4;
    assign k35.IN_row = row35;

    // Event log sampled on the falling edge.
    always @(negedge clk) begin
        if (k4.OUT_key_valid) begin
            v4.push_back(cyc);
            c4.push_back(k4.OUT_key_code);
            if (!k4.OUT_key_held) vh_bad++;
        end
        if (k4.OUT_key_release) begin
            r4.push_back(cyc);
            if (k4.OUT_key_held || !held4_prev) rh_bad++;
        end
        if (k35.OUT_key_valid) begin
            v35.push_back(cyc);
            c35.push_back(k35.OUT_key_code);
            if (!k35.OUT_key_held) vh_bad++;
        end
        if (k35.OUT_key_release) begin
            r35.push_back(cyc);
            if (k35.OUT_key_held || !held35_prev) rh_bad++;
        end
        if ((k4.OUT_key_valid && k4.OUT_key_release) || (k35.OUT_key_valid && k35.OUT_key_release))
            both_bad++;
        held4_prev  = k4.OUT_key_held;
        held35_prev = k35.OUT_key_held;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; keys4 = '0; keys35 = '0; force4 = '0;
        repeat (3) tick();
        total++;
        if ({k4.OUT_col, k4.OUT_key_code, k4.OUT_key_valid, k4.OUT_key_held, k4.OUT_key_release} !== '0) begin
            bad++; $display("FAIL reset_4x4: got %h want 0", {k4.OUT_col, k4.OUT_key_code, k4.OUT_key_valid, k4.OUT_key_held, k4.OUT_key_release});
        end
        total++;
        if ({k35.OUT_col, k35.OUT_key_code, k35.OUT_key_valid, k35.OUT_key_held, k35.OUT_key_release} !== '0) begin
            bad++; $display("FAIL reset_3x5: got %h want 0", {k35.OUT_col, k35.OUT_key_code, k35.OUT_key_valid, k35.OUT_key_held, k35.OUT_key_release});
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (k4.OUT_col !== 4'b0001) begin bad++; $display("FAIL first_col_4x4: got %b want 0001", k4.OUT_col); end
        total++;
        if (k35.OUT_col !== 5'b00001) begin bad++; $display("FAIL first_col_3x5: got %b want 00001", k35.OUT_col); end
    endtask

    // Ghost keys (rows 1 and 3 on col 2) must not stop the column rotation.
    task automatic test_ghost();
        int n0 = v4.size();
        logic [3:0] prev, cur, want;
        int run = 1;
        bit first = 1'b1;
        keys4[1*4+2] = 1'b1; keys4[3*4+2] = 1'b1;
        prev = k4.OUT_col;
        for (int i = 0; i < 48; i++) begin
            tick();
            cur = k4.OUT_col;
            if (cur == prev) run++;
            else begin
                want = (prev == 4'b1000) ? 4'b0001 : 4'(prev << 1);
                total++;
                if (cur !== want) begin bad++; $display("FAIL ghost_rotate: got %b want %b", cur, want); end
                if (!first) begin
                    total++;
                    if (run != SD) begin bad++; $display("FAIL ghost_dwell: got %0d want %0d", run, SD); end
                end
                first = 1'b0; run = 1; prev = cur;
            end
        end
        keys4 = '0;
        total++;
        if (v4.size() != n0) begin bad++; $display("FAIL ghost_event: got %0d want 0", v4.size() - n0); end
    endtask

    // Row 0 high for two synced cycles on col 3: no event, next column is col 0.
    task automatic test_glitch();
        int n0 = v4.size();
        for (int i = 0; i < 40 && k4.OUT_col == 4'b1000; i++) tick();
        for (int i = 0; i < 40 && k4.OUT_col != 4'b1000; i++) tick();
        tick();
        force4 = 4'b0001;
        tick(); tick();
        force4 = 4'b0000;
        for (int i = 0; i < 20 && k4.OUT_col == 4'b1000; i++) tick();
        total++;
        if (k4.OUT_col !== 4'b0001) begin bad++; $display("FAIL glitch_next_col: got %b want 0001", k4.OUT_col); end
        repeat (10) tick();
        total++;
        if (v4.size() != n0) begin bad++; $display("FAIL glitch_event: got %0d want 0", v4.size() - n0); end
    endtask

    task automatic test_clean_press();
        int nv = v4.size();
        int nr = r4.size();
        int drop, lat;
        keys4[2*4+1] = 1'b1;
        for (int i = 0; i < 200 && v4.size() == nv; i++) tick();
        total++;
        if (v4.size() != nv + 1) begin bad++; $display("FAIL press_seen: got %0d want 1", v4.size() - nv); end
        else begin
            total++;
            if (c4[$] !== 4'd9) begin bad++; $display("FAIL press_code: got %0d want 9", c4[$]); end
        end
        total++;
        if (k4.OUT_key_held !== 1'b1) begin bad++; $display("FAIL press_held: got %b want 1", k4.OUT_key_held); end
        repeat (50) tick();
        keys4[2*4+1] = 1'b0;
        drop = cyc;
        for (int i = 0; i < 100 && r4.size() == nr; i++) tick();
        total++;
        if (r4.size() != nr + 1) begin bad++; $display("FAIL release_seen: got %0d want 1", r4.size() - nr); end
        else begin
            lat = r4[$] - drop;
            total++;
            if (lat < DEB + 2 || lat > DEB + 3) begin bad++; $display("FAIL release_latency: got %0d want %0d..%0d", lat, DEB + 2, DEB + 3); end
        end
        repeat (5) tick();
        total++;
        if (v4.size() != nv + 1) begin bad++; $display("FAIL press_once: got %0d want 1", v4.size() - nv); end
        total++;
        if (k4.OUT_key_code !== 4'd9 || k4.OUT_key_held !== 1'b0) begin
            bad++; $display("FAIL after_release: got code=%0d held=%b want code=9 held=0", k4.OUT_key_code, k4.OUT_key_held);
        end
    endtask

    task automatic test_release_bounce();
        int nv = v4.size();
        int nr = r4.size();
        int held_low = 0;
        keys4[1*4+3] = 1'b1;
        for (int i = 0; i < 200 && v4.size() == nv; i++) tick();
        repeat (10) tick();
        keys4[1*4+3] = 1'b0;
        tick(); tick();
        keys4[1*4+3] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!k4.OUT_key_held) held_low++;
        end
        total++;
        if (r4.size() != nr) begin bad++; $display("FAIL bounce_release: got %0d want 0", r4.size() - nr); end
        total++;
        if (v4.size() != nv + 1) begin bad++; $display("FAIL bounce_valid: got %0d want 1", v4.size() - nv); end
        total++;
        if (held_low != 0) begin bad++; $display("FAIL bounce_held: got %0d low cycles want 0", held_low); end
        keys4[1*4+3] = 1'b0;
        for (int i = 0; i < 100 && r4.size() == nr; i++) tick();
        repeat (5) tick();
        total++;
        if (r4.size() != nr + 1) begin bad++; $display("FAIL bounce_final_release: got %0d want 1", r4.size() - nr); end
    endtask

    task automatic test_reset_mid_press();
        int nv = v4.size();
        int nr = r4.size();
        int n1;
        keys4[0*4+2] = 1'b1;
        for (int i = 0; i < 200 && v4.size() == nv; i++) tick();
        repeat (5) tick();
        total++;
        if (k4.OUT_key_held !== 1'b1) begin bad++; $display("FAIL midrst_held_before: got %b want 1", k4.OUT_key_held); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({k4.OUT_col, k4.OUT_key_code, k4.OUT_key_valid, k4.OUT_key_held, k4.OUT_key_release} !== '0) begin
            bad++; $display("FAIL midrst_outputs: got %h want 0", {k4.OUT_col, k4.OUT_key_code, k4.OUT_key_valid, k4.OUT_key_held, k4.OUT_key_release});
        end
        repeat (3) tick();
        rst_n = 1'b1;
        nv = v4.size();
        tick();
        total++;
        if (k4.OUT_col !== 4'b0001) begin bad++; $display("FAIL midrst_col: got %b want 0001", k4.OUT_col); end
        for (int i = 0; i < 200 && v4.size() == nv; i++) tick();
        total++;
        if (v4.size() != nv + 1) begin bad++; $display("FAIL midrst_reaccept: got %0d want 1", v4.size() - nv); end
        else begin
            total++;
            if (c4[$] !== 4'd2) begin bad++; $display("FAIL midrst_code: got %0d want 2", c4[$]); end
        end
        n1 = v4.size();
        repeat (30) tick();
        total++;
        if (v4.size() != n1 || r4.size() != nr) begin
            bad++; $display("FAIL midrst_extra: got valid+%0d release+%0d want 0 0", v4.size() - n1, r4.size() - nr);
        end
        keys4[0*4+2] = 1'b0;
        for (int i = 0; i < 100 && r4.size() == nr; i++) tick();
        repeat (5) tick();
    endtask

    task automatic test_random_keys();
        for (int it = 0; it < 6; it++) begin
            int r = int'($urandom_range(3, 0));
            int c = int'($urandom_range(3, 0));
            int hold = int'($urandom_range(40, 8));
            int nv = v4.size();
            int nr = r4.size();
            keys4 = '0;
            keys4[r*4+c] = 1'b1;
            for (int i = 0; i < 200 && v4.size() == nv; i++) tick();
            total++;
            if (v4.size() != nv + 1) begin bad++; $display("FAIL rand_press r%0d c%0d: got %0d want 1", r, c, v4.size() - nv); end
            else begin
                total++;
                if (c4[$] !== 4'(r * 4 + c)) begin bad++; $display("FAIL rand_code: got %0d want %0d", c4[$], r * 4 + c); end
            end
            repeat (hold) tick();
            keys4 = '0;
            for (int i = 0; i < 100 && r4.size() == nr; i++) tick();
            repeat (3) tick();
            total++;
            if (r4.size() != nr + 1 || v4.size() != nv + 1) begin
                bad++; $display("FAIL rand_counts: got valid=%0d release=%0d want 1 1", v4.size() - nv, r4.size() - nr);
            end
        end
    endtask

    // 3x5 key (2,4): repeats at +REPEAT_DELAY then every REPEAT_RATE when enabled.
    task automatic test_autorepeat();
        int nv = v35.size();
        int nr = r35.size();
        int hold = 61;
        int a, got;
        int expq[$];
        keys35[2*5+4] = 1'b1;
        for (int i = 0; i < 200 && v35.size() == nv; i++) tick();
        total++;
        if (v35.size() != nv + 1) begin bad++; $display("FAIL rep_press: got %0d want 1", v35.size() - nv); end
        else begin
            total++;
            if (c35[nv] !== 4'd14) begin bad++; $display("FAIL rep_code: got %0d want 14", c35[nv]); end
        end
        a = (v35.size() > nv) ? v35[nv] : cyc;
        repeat (hold) tick();
        keys35 = '0;
        for (int i = 0; i < 100 && r35.size() == nr; i++) tick();
        repeat (3) tick();
        for (int k = 0; k <= hold; k++)
            if (k == 0 || (REP_EN && k >= int'(R35_DELAY) && (k - int'(R35_DELAY)) % int'(R35_RATE) == 0))
                expq.push_back(k);
        got = v35.size() - nv;
        total++;
        if (got != expq.size()) begin bad++; $display("FAIL rep_count: got %0d want %0d", got, expq.size()); end
        for (int i = 0; i < expq.size() && i < got; i++) begin
            total++;
            if (v35[nv + i] - a != expq[i]) begin bad++; $display("FAIL rep_offset[%0d]: got %0d want %0d", i, v35[nv + i] - a, expq[i]); end
        end
        total++;
        if (r35.size() != nr + 1) begin bad++; $display("FAIL rep_release: got %0d want 1", r35.size() - nr); end
    endtask

    task automatic test_invariants();
        total++;
        if (vh_bad != 0) begin bad++; $display("FAIL valid_without_held: got %0d want 0", vh_bad); end
        total++;
        if (rh_bad != 0) begin bad++; $display("FAIL release_held_edge: got %0d want 0", rh_bad); end
        total++;
        if (both_bad != 0) begin bad++; $display("FAIL valid_and_release: got %0d want 0", both_bad); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ghost();
        test_glitch();
        test_clean_press();
        test_release_bounce();
        test_reset_mid_press();
        test_random_keys();
        test_autorepeat();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
